// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the 16-bit RISC pipeline: opcodes, write-back modes
// and the hazard controller state encodings.
package pipeline_hazard_ctrl_pkg;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h03;
    localparam logic [5:0] OP_JMP = 6'h10;
    localparam logic [5:0] OP_JZ  = 6'h11;
    localparam logic [5:0] OP_JNZ = 6'h12;
    localparam logic [5:0] OP_JAL = 6'h13;

    localparam logic [2:0] WB_NOP  = 3'd0;
    localparam logic [2:0] WB_REG  = 3'd1;
    localparam logic [2:0] WB_REGH = 3'd2;
    localparam logic [2:0] WB_REGL = 3'd3;
    localparam logic [2:0] WB_MEMW = 3'd4;
    localparam logic [2:0] WB_MEMR = 3'd5;
    localparam logic [2:0] WB_MUL  = 3'd6;

    localparam logic [1:0] CTRL_RUN      = 2'd0;
    localparam logic [1:0] CTRL_MUL_WAIT = 2'd1;
    localparam logic [1:0] CTRL_FLUSH    = 2'd2;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/execute/memory sideband into the hazard controller and its stall,
// bubble and redirect controls back to the pipeline stages.
interface pipeline_hazard_ctrl_if #(parameter int REG_AW = 4);
    logic              id_valid;
    logic [5:0]        id_opcode;
    logic [REG_AW-1:0] id_src1;
    logic              id_src1_used;
    logic [REG_AW-1:0] id_src2;
    logic              id_src2_used;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_dst_we;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_dst_we;
    logic              ex_jump_ctl;
    logic [15:0]       ex_jump_pc;
    logic              stall_if;
    logic              stall_id;
    logic              bubble_ex;
    logic              pc_load;
    logic [15:0]       pc_target;
    logic              mul_busy;

    // No handshake: every field is a level, the controls are combinational
    // from the current inputs and act on the next clock edge.
    modport master (
        output id_valid, id_opcode, id_src1, id_src1_used, id_src2, id_src2_used,
        output ex_dst, ex_dst_we, mem_dst, mem_dst_we, ex_jump_ctl, ex_jump_pc,
        input  stall_if, stall_id, bubble_ex, pc_load, pc_target, mul_busy
    );

    modport slave (
        input  id_valid, id_opcode, id_src1, id_src1_used, id_src2, id_src2_used,
        input  ex_dst, ex_dst_we, mem_dst, mem_dst_we, ex_jump_ctl, ex_jump_pc,
        output stall_if, stall_id, bubble_ex, pc_load, pc_target, mul_busy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW comparator between decode sources and the in-flight
// execute/memory destinations.
module hazard_detect #(
    parameter int REG_AW = 4
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_dst_we,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_dst_we,
    output logic              raw
);
    logic src1_hit;
    logic src2_hit;

    assign src1_hit = id_src1_used &
                      ((ex_dst_we & (id_src1 == ex_dst)) | (mem_dst_we & (id_src1 == mem_dst)));
    assign src2_hit = id_src2_used &
                      ((ex_dst_we & (id_src2 == ex_dst)) | (mem_dst_we & (id_src2 == mem_dst)));
    assign raw = id_valid & (src1_hit | src2_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: RAW stalls, multi-cycle MUL hold and jump redirect/flush.
// All controls are Mealy outputs of the RUN/MUL_WAIT/FLUSH state machine.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int REG_AW      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus,
    output logic [1:0]            dbg_state
);
    localparam int CNT_MAX = (MUL_LATENCY > FLUSH_DEPTH) ? MUL_LATENCY : FLUSH_DEPTH;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_DEPTH - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

    logic [1:0]       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic             raw, jump_now, mul_go;
    logic             stall, bubble, load, busy;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .id_valid     (bus.id_valid),
        .id_src1      (bus.id_src1),
        .id_src1_used (bus.id_src1_used),
        .id_src2      (bus.id_src2),
        .id_src2_used (bus.id_src2_used),
        .ex_dst       (bus.ex_dst),
        .ex_dst_we    (bus.ex_dst_we),
        .mem_dst      (bus.mem_dst),
        .mem_dst_we   (bus.mem_dst_we),
        .raw          (raw)
    );

    // A jump seen while flushing belongs to an already-squashed instruction.
    assign jump_now = bus.ex_jump_ctl & (state != CTRL_FLUSH);
    assign mul_go   = bus.id_valid & (bus.id_opcode == OP_MUL) & ~raw;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        stall      = 1'b0;
        bubble     = 1'b0;
        load       = 1'b0;
        busy       = 1'b0;
        if (jump_now) begin
            load       = 1'b1;
            bubble     = 1'b1;
            next_cnt   = FLUSH_LOAD;
            next_state = (FLUSH_DEPTH > 1) ? CTRL_FLUSH : CTRL_RUN;
        end else begin
            case (state)
                CTRL_RUN: begin
                    if (mul_go) begin
                        busy = 1'b1;
                        if (MUL_LATENCY > 1) begin
                            next_cnt   = MUL_LOAD;
                            next_state = CTRL_MUL_WAIT;
                        end
                    end else if (raw) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end
                end
                CTRL_MUL_WAIT: begin
                    stall = 1'b1;
                    busy  = 1'b1;
                    if (cnt == '0) begin
                        next_state = CTRL_RUN;
                    end else begin
                        next_cnt = cnt - 1'b1;
                    end
                end
                CTRL_FLUSH: begin
                    // The jump cycle itself is the first bubble, so FLUSH spans
                    // FLUSH_DEPTH-1 cycles and leaves as cnt runs down to zero.
                    bubble = 1'b1;
                    if (cnt <= CNT_W'(1)) begin
                        next_state = CTRL_RUN;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt - 1'b1;
                    end
                end
                default: begin
                    next_state = CTRL_RUN;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CTRL_RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    assign bus.stall_if  = stall & ~rst;
    assign bus.stall_id  = stall & ~rst;
    assign bus.bubble_ex = bubble & ~rst;
    assign bus.pc_load   = load & ~rst;
    assign bus.mul_busy  = busy & ~rst;
    assign bus.pc_target = (load & ~rst) ? bus.ex_jump_pc : 16'h0000;
    assign dbg_state     = state;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MUL_LATENCY=4, FLUSH_DEPTH=2).
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [5:0]  op;
        logic [3:0]  s1;
        logic        s1u;
        logic [3:0]  s2;
        logic        s2u;
        logic [3:0]  exd;
        logic        exw;
        logic [3:0]  md;
        logic        mw;
        logic        jmp;
        logic [15:0] jpc;
    } in_t;

    typedef struct {
        in_t         i;
        logic [22:0] e;
        string       nm;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         errors;
    int         checks;
    logic [22:0] exp_q[$];
    string       name_q[$];
    vec_t        tbl[8];

    pipeline_hazard_ctrl_if #(.REG_AW(4)) bus ();

    pipeline_hazard_ctrl #(.MUL_LATENCY(4), .FLUSH_DEPTH(2), .REG_AW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t idle();
        in_t v;
        v.rst = 1'b0; v.vld = 1'b0; v.op = OP_NOP;
        v.s1 = 4'd0; v.s1u = 1'b0; v.s2 = 4'd0; v.s2u = 1'b0;
        v.exd = 4'd0; v.exw = 1'b0; v.md = 4'd0; v.mw = 1'b0;
        v.jmp = 1'b0; v.jpc = 16'h0000;
        return v;
    endfunction

    function automatic in_t mk(logic vld, logic [5:0] op, logic [3:0] s1, logic s1u,
                               logic [3:0] s2, logic s2u, logic [3:0] exd, logic exw,
                               logic [3:0] md, logic mw);
        in_t v;
        v = idle();
        v.vld = vld; v.op = op; v.s1 = s1; v.s1u = s1u; v.s2 = s2; v.s2u = s2u;
        v.exd = exd; v.exw = exw; v.md = md; v.mw = mw;
        return v;
    endfunction

    // Packs {stall_if, stall_id, bubble_ex, pc_load, mul_busy, pc_target, state}.
    function automatic logic [22:0] ex(logic st, logic bub, logic pl, logic mb,
                                       logic [15:0] pt, logic [1:0] s);
        return {st, st, bub, pl, mb, pt, s};
    endfunction

    task automatic drive(input in_t v);
        rst              = v.rst;
        bus.id_valid     = v.vld;
        bus.id_opcode    = v.op;
        bus.id_src1      = v.s1;
        bus.id_src1_used = v.s1u;
        bus.id_src2      = v.s2;
        bus.id_src2_used = v.s2u;
        bus.ex_dst       = v.exd;
        bus.ex_dst_we    = v.exw;
        bus.mem_dst      = v.md;
        bus.mem_dst_we   = v.mw;
        bus.ex_jump_ctl  = v.jmp;
        bus.ex_jump_pc   = v.jpc;
    endtask

    task automatic check_out();
        logic [22:0] got;
        logic [22:0] want;
        string       nm;
        got  = {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.pc_load, bus.mul_busy,
                bus.pc_target, dbg_state};
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got si/sd/bub/pl/mb/pt/st=%b/%b/%b/%b/%b/%h/%0d want %b/%b/%b/%b/%b/%h/%0d",
                     nm, got[22], got[21], got[20], got[19], got[18], got[17:2], got[1:0],
                     want[22], want[21], want[20], want[19], want[18], want[17:2], want[1:0]);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
    task automatic step(input in_t v, input logic [22:0] e, input string nm);
        @(posedge clk);
        #1;
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        in_t v;
        in_t mulv;
        logic model_raw;
        errors = 0;
        checks = 0;

        tbl[0] = '{mk(1'b0, OP_NOP, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0),
                   ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "idle"};
        tbl[1] = '{mk(1'b1, OP_ADD, 4'd3, 1'b1, 4'd9, 1'b1, 4'd3, 1'b1, 4'd7, 1'b0),
                   ex(1, 1, 0, 0, 16'h0, CTRL_RUN), "raw_src1_ex"};
        tbl[2] = '{mk(1'b1, OP_SUB, 4'd1, 1'b1, 4'd6, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1),
                   ex(1, 1, 0, 0, 16'h0, CTRL_RUN), "raw_src2_mem"};
        tbl[3] = '{mk(1'b1, OP_ADD, 4'd3, 1'b0, 4'd4, 1'b1, 4'd3, 1'b1, 4'd7, 1'b1),
                   ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "src1_unused"};
        tbl[4] = '{mk(1'b0, OP_ADD, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1),
                   ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "id_invalid"};
        tbl[5] = '{mk(1'b1, OP_ADD, 4'd5, 1'b1, 4'd8, 1'b1, 4'd5, 1'b0, 4'd8, 1'b0),
                   ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "dst_no_we"};
        tbl[6] = '{mk(1'b1, OP_MUL, 4'd2, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 4'd0, 1'b0),
                   ex(1, 1, 0, 0, 16'h0, CTRL_RUN), "mul_raw_waits"};
        tbl[7] = '{mk(1'b1, OP_ADD, 4'd12, 1'b1, 4'd1, 1'b1, 4'd0, 1'b1, 4'd12, 1'b1),
                   ex(1, 1, 0, 0, 16'h0, CTRL_RUN), "raw_src1_mem"};

        drive(idle());
        rst = 1'b1;
        v = idle(); v.rst = 1'b1;
        step(v, ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "reset");
        step(idle(), ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "after_reset");

        for (int k = 0; k < 8; k++) begin
            step(tbl[k].i, tbl[k].e, tbl[k].nm);
        end

        // Test 1: ex hazard, then the producer moves to memory, then retires.
        v = mk(1'b1, OP_ADD, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0);
        step(v, ex(1, 1, 0, 0, 16'h0, CTRL_RUN), "t1_ex_stall");
        v.exd = 4'd5; v.md = 4'd3; v.mw = 1'b1;
        step(v, ex(1, 1, 0, 0, 16'h0, CTRL_RUN), "t1_mem_stall");
        v.md = 4'd7;
        step(v, ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "t1_clear");

        // Test 2: MUL occupies execute for four cycles.
        mulv = mk(1'b1, OP_MUL, 4'd1, 1'b1, 4'd2, 1'b1, 4'd9, 1'b1, 4'd10, 1'b1);
        step(mulv, ex(0, 0, 0, 1, 16'h0, CTRL_RUN), "t2_mul_c1");
        step(mulv, ex(1, 0, 0, 1, 16'h0, CTRL_MUL_WAIT), "t2_mul_c2");
        step(mulv, ex(1, 0, 0, 1, 16'h0, CTRL_MUL_WAIT), "t2_mul_c3");
        step(mulv, ex(1, 0, 0, 1, 16'h0, CTRL_MUL_WAIT), "t2_mul_c4");
        step(idle(), ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "t2_mul_c5");

        // Test 3: jump redirect, second jump during flush ignored.
        v = idle(); v.jmp = 1'b1; v.jpc = 16'h0040;
        step(v, ex(0, 1, 1, 0, 16'h0040, CTRL_RUN), "t3_jump");
        v.jpc = 16'h0080;
        step(v, ex(0, 1, 0, 0, 16'h0, CTRL_FLUSH), "t3_flush_ignore");
        step(idle(), ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "t3_back_run");

        // Test 4: jump beats a hazarded MUL in the same cycle.
        v = mk(1'b1, OP_MUL, 4'd1, 1'b1, 4'd4, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0);
        v.jmp = 1'b1; v.jpc = 16'h0100;
        step(v, ex(0, 1, 1, 0, 16'h0100, CTRL_RUN), "t4_jump_wins");
        step(idle(), ex(0, 1, 0, 0, 16'h0, CTRL_FLUSH), "t4_flush");
        step(idle(), ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "t4_run");

        // Test 5: reset in the middle of MUL_WAIT.
        step(mulv, ex(0, 0, 0, 1, 16'h0, CTRL_RUN), "t5_mul_c1");
        v = idle(); v.rst = 1'b1;
        step(v, ex(0, 0, 0, 0, 16'h0, CTRL_MUL_WAIT), "t5_rst_in_wait");
        v = mk(1'b1, OP_ADD, 4'd1, 1'b1, 4'd2, 1'b1, 4'd5, 1'b1, 4'd6, 1'b1);
        step(v, ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "t5_add_passes");

        // Jump aborts a MUL in progress.
        step(mulv, ex(0, 0, 0, 1, 16'h0, CTRL_RUN), "abort_mul_c1");
        v = idle(); v.jmp = 1'b1; v.jpc = 16'h0200;
        step(v, ex(0, 1, 1, 0, 16'h0200, CTRL_MUL_WAIT), "abort_jump");
        step(idle(), ex(0, 1, 0, 0, 16'h0, CTRL_FLUSH), "abort_flush");
        step(idle(), ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "abort_run");

        // Reset in the middle of FLUSH: no pc_load afterwards.
        v = idle(); v.jmp = 1'b1; v.jpc = 16'h0300;
        step(v, ex(0, 1, 1, 0, 16'h0300, CTRL_RUN), "rflush_jump");
        v = idle(); v.rst = 1'b1;
        step(v, ex(0, 0, 0, 0, 16'h0, CTRL_FLUSH), "rflush_rst");
        step(idle(), ex(0, 0, 0, 0, 16'h0, CTRL_RUN), "rflush_run");

        // Random non-MUL, non-jump traffic against an independent RAW model.
        for (int k = 0; k < 24; k++) begin
            v = mk(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 2) == 0) ? 6'h3F : OP_ADD,
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            model_raw = v.vld &&
                        ((v.s1u && ((v.exw && v.s1 == v.exd) || (v.mw && v.s1 == v.md))) ||
                         (v.s2u && ((v.exw && v.s2 == v.exd) || (v.mw && v.s2 == v.md))));
            step(v, ex(model_raw, model_raw, 0, 0, 16'h0, CTRL_RUN), "rand_raw");
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 16-bit RISC pipeline, sitting beside the fetch/decode/execute stages.
- Detects RAW hazards between the decode-stage sources and the execute/memory-stage destinations.
- Holds the front end while a multi-cycle MUL occupies the ALU.
- Redirects the PC and inserts bubbles when the execute stage reports a taken jump.
- All stall, bubble and redirect decisions for the pipeline come from this block.

Parameters:
- MUL_LATENCY, 4: ALU cycles a MUL occupies execute; legal range >= 1.
- FLUSH_DEPTH, 2: bubbles injected after a taken jump; legal range >= 1.
- REG_AW, 4: register-index width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_opcode  in  6  decode opcode
- id_src1  in  REG_AW  decode source register 1
- id_src1_used  in  1  src1 is read by the instruction
- id_src2  in  REG_AW  decode source register 2
- id_src2_used  in  1  src2 is read by the instruction
- ex_dst  in  REG_AW  execute-stage destination register
- ex_dst_we  in  1  execute will write ex_dst (WB_REG, WB_REGH or WB_REGL)
- mem_dst  in  REG_AW  memory-stage destination register
- mem_dst_we  in  1  memory stage will write mem_dst
- ex_jump_ctl  in  1  taken jump from execute
- ex_jump_pc  in  16  jump target
- stall_if  out  1  hold PC and fetch register
- stall_id  out  1  hold decode register
- bubble_ex  out  1  force NOP opcode into execute next edge
- pc_load  out  1  load pc_target into PC
- pc_target  out  16  redirect address
- mul_busy  out  1  MUL in progress

Behaviour:
- States: RUN, MUL_WAIT, FLUSH. Counters: cnt, wide enough for max(MUL_LATENCY, FLUSH_DEPTH).
- Reset: state=RUN, cnt=0. All outputs are 0 during reset and in the cycle after reset deassertion unless the inputs request otherwise in RUN.
- Outputs are Mealy, combinational from state and current inputs. No added latency.
- pc_target = ex_jump_pc whenever pc_load=1, else 0.
- raw = id_valid & ((id_src1_used & ((ex_dst_we & id_src1==ex_dst) | (mem_dst_we & id_src1==mem_dst))) | same terms for src2).
- RUN priority is jump > MUL > raw:
  - ex_jump_ctl: pc_load=1, bubble_ex=1, stall_if=stall_id=0 (the redirect overwrites fetch). cnt<=FLUSH_DEPTH-1. Next state is FLUSH if FLUSH_DEPTH>1, else RUN. Any MUL or raw in decode is squashed.
  - id_valid & id_opcode==MUL & !raw: the MUL advances to execute, mul_busy=1. If MUL_LATENCY>1 then cnt<=MUL_LATENCY-2 and next state is MUL_WAIT; else stay in RUN.
  - raw: stall_if=stall_id=1, bubble_ex=1. Stay in RUN. Re-evaluate each cycle.
  - Otherwise all outputs are 0.
- MUL_WAIT:
  - stall_if=stall_id=1, bubble_ex=0 (execute holds the MUL), mul_busy=1.
  - cnt decrements each cycle; at cnt==0 go to RUN.
  - ex_jump_ctl in MUL_WAIT behaves as a RUN jump: it aborts the MUL sequence and goes to FLUSH or RUN.
- FLUSH:
  - bubble_ex=1, stall_if=stall_id=0.
  - ex_jump_ctl is ignored, since it comes from squashed instructions.
  - cnt decrements; at cnt==0 go to RUN.
- Simultaneous jump and MUL, or jump and raw: the jump wins and nothing stalls.
- MUL with a raw hazard: the raw stall applies first; the MUL is accepted once raw clears.
- rst asserted mid-MUL_WAIT or mid-FLUSH: next state=RUN, cnt=0. No pc_load follows.
- Undefined opcodes are treated as non-MUL.

Decomposition:
- Shared defines/package holds:
  - the opcode constants (NOP, MUL, jump family);
  - the WB mode constants (WB_NOP, WB_REG, WB_REGH, WB_REGL, WB_MEM*, WB_MUL);
  - the controller state encodings CTRL_RUN, CTRL_MUL_WAIT, CTRL_FLUSH.
- Sub-module hazard_detect: purely combinational raw comparator, reused later by a forwarding unit.

Test Plan:
1. ex_dst=3, ex_dst_we=1; decode id_src1=3, used, ADD -> stall_if=stall_id=bubble_ex=1. With mem_dst=3 next cycle, stall persists one more cycle, then clears.
2. MUL in decode, MUL_LATENCY=4, no hazards -> mul_busy high 4 cycles, stall_if high for cycles 2-4, state back to RUN on cycle 5.
3. ex_jump_ctl=1, ex_jump_pc=16'h0040 -> pc_load=1, pc_target=16'h0040 the same cycle. bubble_ex=1 for 2 cycles (FLUSH_DEPTH=2). A second ex_jump_ctl in cycle 2 is ignored.
4. Same cycle: ex_jump_ctl=1 (pc 16'h0100), MUL in decode with raw on src2 -> pc_load=1, stall_if=0, mul_busy=0, state to FLUSH.
5. rst=1 during MUL_WAIT cycle 2 -> next cycle all outputs 0, state RUN. A subsequent ADD with no hazard passes with no stall.
6. src1 matches ex_dst but id_src1_used=0, or id_valid=0 -> no stall.
